// File: rtl/inversor_response_checker_pkg.sv
// rtl/inversor_response_checker_pkg.sv - shared FSM encoding, LFSR taps and default seed
package inversor_response_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register
    localparam logic [7:0] LFSR_TAP_MASK = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED  = 8'hA5;

    function automatic logic lfsr_feedback(input logic [7:0] q);
        return ^(q & LFSR_TAP_MASK);
    endfunction

endpackage

// File: rtl/lfsr_8bit.sv
// rtl/lfsr_8bit.sv - 8-bit Fibonacci LFSR with synchronous load and advance
module lfsr_8bit
    import inversor_response_checker_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       advance,
    output logic [7:0] q
);

    logic [7:0] q_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            q_q <= SEED;
        end else if (load) begin
            q_q <= seed;
        end else if (advance) begin
            q_q <= {q_q[6:0], lfsr_feedback(q_q)};
        end
    end

    assign q = q_q;

endmodule

// File: rtl/inversor_response_checker.sv
// rtl/inversor_response_checker.sv - drives an inverter with LFSR vectors and checks its complement
module inversor_response_checker
    import inversor_response_checker_pkg::*;
#(
    parameter int unsigned NUM_VECTORS   = 16,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  SEED          = DEFAULT_SEED,
    parameter int unsigned ERR_W         = 8,
    localparam int unsigned IDX_W        = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    input  logic             dut_out,
    output logic             drive_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_err_idx
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               drive_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [ERR_W-1:0]   err_q;
    logic [ERR_W-1:0]   err_d;
    logic [IDX_W-1:0]   first_q;
    logic [7:0]         lfsr_q;
    logic               lfsr_load;
    logic               lfsr_adv;
    logic               next_bit;
    logic               mismatch;
    logic               last_vec;

    always_comb begin
        last_vec  = (idx_q == IDX_W'(NUM_VECTORS - 1));
        mismatch  = (dut_out != ~drive_q);
        lfsr_load = (state_q == ST_IDLE) && start;
        lfsr_adv  = (state_q == ST_CHECK) && !last_vec;
        next_bit  = lfsr_feedback(lfsr_q);
        err_d     = err_q;
        if (mismatch && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
    end

    lfsr_8bit #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .reset_L (reset_L),
        .load    (lfsr_load),
        .seed    (SEED),
        .advance (lfsr_adv),
        .q       (lfsr_q)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            drive_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        drive_q <= SEED[0];
                        err_q   <= '0;
                        first_q <= '0;
                        pass_q  <= 1'b0;
                        idx_q   <= '0;
                        cnt_q   <= CNT_W'(SETTLE_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    err_q <= err_d;
                    // A zero count before this vector means no earlier mismatch in the run
                    if (mismatch && (err_q == '0)) begin
                        first_q <= idx_q;
                    end
                    if (!last_vec) begin
                        drive_q <= next_bit;
                        idx_q   <= idx_q + 1'b1;
                        cnt_q   <= CNT_W'(SETTLE_CYCLES);
                        state_q <= ST_SETTLE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    pass_q  <= (err_q == '0);
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign drive_out     = drive_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_inversor_response_checker.sv
// tb/tb_inversor_response_checker.sv - scoreboard bench for inversor_response_checker
module tb_inversor_response_checker;

    localparam int N  = 8;
    localparam int S  = 2;
    localparam int EW = 2;
    localparam int IW = 3;
    localparam int L  = N * (S + 1);
    localparam logic [7:0] SD = 8'hA5;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          start;
    logic          dut_out;
    logic          drive_out;
    logic          busy;
    logic          done;
    logic          pass;
    logic [EW-1:0] err_count;
    logic [IW-1:0] first_err_idx;

    inversor_response_checker #(
        .NUM_VECTORS   (N),
        .SETTLE_CYCLES (S),
        .SEED          (SD),
        .ERR_W         (EW)
    ) dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .start         (start),
        .dut_out       (dut_out),
        .drive_out     (drive_out),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Inverter model: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 per-vector flips
    int           mode = 0;
    logic [N-1:0] flip_mask = '0;
    logic         flip = 1'b0;
    int           acc = -1000;
    bit           armed = 1'b0;
    logic [N-1:0] exp_bits;
    int           busy_cnt = 0;

    assign dut_out = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (~drive_out ^ flip);

    typedef struct {
        int            done_cyc;
        logic [EW-1:0] err;
        logic [IW-1:0] first;
        logic          pass;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [N-1:0] ref_bits();
        logic [7:0]   s;
        logic [N-1:0] b;
        s = SD;
        for (int v = 0; v < N; v++) begin
            b[v] = s[0];
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
        return b;
    endfunction

    function automatic exp_t ref_result(input int md, input logic [N-1:0] m, input int done_at);
        exp_t e;
        int   cnt;
        bit   found;
        logic resp;
        cnt = 0;
        found = 0;
        e.first = '0;
        for (int v = 0; v < N; v++) begin
            resp = (md == 1) ? 1'b0 : (md == 2) ? 1'b1 : (~exp_bits[v] ^ ((md == 3) ? m[v] : 1'b0));
            if (resp != ~exp_bits[v]) begin
                if (!found) e.first = IW'(v);
                found = 1;
                cnt++;
            end
        end
        e.err      = (cnt > 3) ? EW'(3) : EW'(cnt);
        e.pass     = (cnt == 0);
        e.done_cyc = done_at;
        return e;
    endfunction

    always @(negedge clk) begin
        int m;
        m = cyc - acc;
        if (armed && m >= 0 && m < L) begin
            flip = (mode == 3) ? flip_mask[m / (S + 1)] : 1'b0;
            if (m % (S + 1) == S)
                check("drive_bit", drive_out, exp_bits[m / (S + 1)]);
        end else begin
            flip = 1'b0;
        end
        if (busy) busy_cnt++;
    end

    always @(negedge clk) begin
        if (reset_L && done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("done_cycle", cyc, mon_e.done_cyc);
                check("err_count", err_count, mon_e.err);
                check("first_err_idx", first_err_idx, mon_e.first);
                check("pass", pass, mon_e.pass);
                check("busy_at_done", busy, 0);
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_drive_out", drive_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_count", err_count, 0);
        check("rst_first_err_idx", first_err_idx, 0);
    endtask

    task automatic run_one(input int md, input logic [N-1:0] m);
        @(negedge clk);
        mode = md;
        flip_mask = m;
        busy_cnt = 0;
        start = 1'b1;
        acc = cyc + 1;
        armed = 1'b1;
        sbq.push_back(ref_result(md, m, acc + L + 1));
        @(negedge clk);
        start = 1'b0;
        repeat (L + 3) @(negedge clk);
        check("busy_cycles", busy_cnt, L);
    endtask

    initial begin
        reset_L = 1'b0;
        start = 1'b0;
        exp_bits = ref_bits();
        repeat (2) @(negedge clk);
        check_reset_vals();
        reset_L = 1'b1;
        repeat (3) @(negedge clk);

        run_one(0, '0);
        run_one(1, '0);
        run_one(2, '0);

        // start held high: one run per IDLE visit, back-to-back
        @(negedge clk);
        mode = 0;
        flip_mask = '0;
        busy_cnt = 0;
        start = 1'b1;
        acc = cyc + 1;
        armed = 1'b1;
        sbq.push_back(ref_result(0, '0, acc + L + 1));
        sbq.push_back(ref_result(0, '0, acc + (L + 2) + L + 1));
        repeat (40) @(negedge clk);
        start = 1'b0;
        repeat (L) @(negedge clk);
        check("busy_cycles_held", busy_cnt, 2 * L);
        check("queue_after_held", sbq.size(), 0);

        // abort in SETTLE of vector 2; no done may follow
        @(negedge clk);
        mode = 3;
        flip_mask = '1;
        start = 1'b1;
        acc = cyc + 1;
        armed = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * (S + 1)) @(negedge clk);
        #2 reset_L = 1'b0;
        #1 check_reset_vals();
        armed = 1'b0;
        @(negedge clk);
        reset_L = 1'b1;
        repeat (L + 4) @(negedge clk);

        run_one(3, N'($urandom));
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_one($urandom_range(0, 3), N'($urandom));
        end

        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
